sha2_msg_schedule: RTL and testbench

//  Parametrised SHA-2 message-schedule generator with a 16-word sliding window.

---
 rtl/sha2_msg_schedule.sv | 190 +++++++++++++++++++
 tb/tb_sha2_msg_schedule.sv | 296 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sha2_msg_schedule.sv
// SHA-2 message-schedule generator: loads a 16-word block, then streams W[0..ROUNDS-1] from a sliding window.
// Optional build macro SHA2_WSCHED_CHKSUM_EN adds a CHKSUM output (XOR of all emitted words since START).
module sha2_msg_schedule #(
    parameter  int WORD_W = 32,
    parameter  int ROUNDS = 64,
    localparam int IDX_W  = $clog2(ROUNDS)
) (
    input  logic              CLK,
    input  logic              RST_N,
    input  logic              START,
    input  logic              ABORT,
    input  logic              IN_VALID,
    output logic              IN_READY,
    input  logic [WORD_W-1:0] IN_DATA,
    output logic              OUT_VALID,
    input  logic              OUT_READY,
    output logic [WORD_W-1:0] OUT_DATA,
    output logic [IDX_W-1:0]  OUT_IDX,
    output logic              BUSY,
    output logic              DONE
`ifdef SHA2_WSCHED_CHKSUM_EN
    ,
    output logic [WORD_W-1:0] CHKSUM
`endif
);

    generate
        if (WORD_W != 32 && WORD_W != 64) begin : g_bad_word_w
            $error("sha2_msg_schedule: WORD_W must be 32 or 64");
        end
    endgenerate

    localparam int S0_A = (WORD_W == 32) ? 7  : 1;
    localparam int S0_B = (WORD_W == 32) ? 18 : 8;
    localparam int S0_C = (WORD_W == 32) ? 3  : 7;
    localparam int S1_A = (WORD_W == 32) ? 17 : 19;
    localparam int S1_B = (WORD_W == 32) ? 19 : 61;
    localparam int S1_C = (WORD_W == 32) ? 10 : 6;

    localparam logic [IDX_W-1:0] LAST_LOAD_IDX  = IDX_W'(15);
    localparam logic [IDX_W-1:0] LAST_ROUND_IDX = IDX_W'(ROUNDS - 1);
    localparam logic [IDX_W-1:0] IDX_ONE        = IDX_W'(1);
    localparam logic [IDX_W-1:0] IDX_ZERO       = IDX_W'(0);
    localparam logic [WORD_W-1:0] WORD_ZERO     = {WORD_W{1'b0}};

    function automatic logic [WORD_W-1:0] rotr(input logic [WORD_W-1:0] x, input int n);
        return (x >> n) | (x << (WORD_W - n));
    endfunction

    function automatic logic [WORD_W-1:0] sig0(input logic [WORD_W-1:0] x);
        return rotr(x, S0_A) ^ rotr(x, S0_B) ^ (x >> S0_C);
    endfunction

    function automatic logic [WORD_W-1:0] sig1(input logic [WORD_W-1:0] x);
        return rotr(x, S1_A) ^ rotr(x, S1_B) ^ (x >> S1_C);
    endfunction

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_EMIT = 2'd2
    } state_t;

    state_t            state_r;
    logic [WORD_W-1:0] win_r [16];
    logic [IDX_W-1:0]  count_r;
    logic              in_ready_r;
    logic              out_valid_r;
    logic              busy_r;
    logic              done_r;
    logic              in_hs_s;
    logic              out_hs_s;
    logic [WORD_W-1:0] w_next_s;

    assign in_hs_s  = IN_VALID & in_ready_r;
    assign out_hs_s = out_valid_r & OUT_READY;
    // win_r[0] is W[t]; the new tail word is W[t+16] = s1(W[t+14]) + W[t+9] + s0(W[t+1]) + W[t]
    assign w_next_s = sig1(win_r[14]) + win_r[9] + sig0(win_r[1]) + win_r[0];

    assign IN_READY  = in_ready_r;
    assign OUT_VALID = out_valid_r;
    assign OUT_DATA  = win_r[0];
    assign OUT_IDX   = count_r;
    assign BUSY      = busy_r;
    assign DONE      = done_r;

    // Control FSM, input capture and window shift; ABORT overrides everything else
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_r     <= ST_IDLE;
            count_r     <= IDX_ZERO;
            in_ready_r  <= 1'b0;
            out_valid_r <= 1'b0;
            busy_r      <= 1'b0;
            done_r      <= 1'b0;
            for (int i = 0; i < 16; i++) begin
                win_r[i] <= WORD_ZERO;
            end
        end else if (ABORT) begin
            state_r     <= ST_IDLE;
            count_r     <= IDX_ZERO;
            in_ready_r  <= 1'b0;
            out_valid_r <= 1'b0;
            busy_r      <= 1'b0;
            done_r      <= 1'b0;
            for (int i = 0; i < 16; i++) begin
                win_r[i] <= WORD_ZERO;
            end
        end else begin
            done_r <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    if (START) begin
                        state_r    <= ST_LOAD;
                        count_r    <= IDX_ZERO;
                        in_ready_r <= 1'b1;
                        busy_r     <= 1'b1;
                    end else begin
                        state_r <= ST_IDLE;
                    end
                end
                ST_LOAD: begin
                    if (in_hs_s) begin
                        win_r[count_r[3:0]] <= IN_DATA;
                        if (count_r == LAST_LOAD_IDX) begin
                            state_r     <= ST_EMIT;
                            count_r     <= IDX_ZERO;
                            in_ready_r  <= 1'b0;
                            out_valid_r <= 1'b1;
                        end else begin
                            count_r <= count_r + IDX_ONE;
                        end
                    end else begin
                        state_r <= ST_LOAD;
                    end
                end
                ST_EMIT: begin
                    if (out_hs_s) begin
                        for (int i = 0; i < 15; i++) begin
                            win_r[i] <= win_r[i+1];
                        end
                        win_r[15] <= w_next_s;
                        if (count_r == LAST_ROUND_IDX) begin
                            state_r     <= ST_IDLE;
                            count_r     <= IDX_ZERO;
                            out_valid_r <= 1'b0;
                            busy_r      <= 1'b0;
                            done_r      <= 1'b1;
                        end else begin
                            count_r <= count_r + IDX_ONE;
                        end
                    end else begin
                        state_r <= ST_EMIT;
                    end
                end
                default: begin
                    state_r     <= ST_IDLE;
                    count_r     <= IDX_ZERO;
                    in_ready_r  <= 1'b0;
                    out_valid_r <= 1'b0;
                    busy_r      <= 1'b0;
                end
            endcase
        end
    end

`ifdef SHA2_WSCHED_CHKSUM_EN
    logic [WORD_W-1:0] chksum_r;

    // Running XOR of handshaken output words, restarted by an accepted START
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            chksum_r <= WORD_ZERO;
        end else if (ABORT) begin
            chksum_r <= WORD_ZERO;
        end else if (state_r == ST_IDLE && START) begin
            chksum_r <= WORD_ZERO;
        end else if (out_hs_s) begin
            chksum_r <= chksum_r ^ win_r[0];
        end else begin
            chksum_r <= chksum_r;
        end
    end

    assign CHKSUM = chksum_r;
`else
    // This build carries no checksum state.
`endif

endmodule

// File: tb/tb_sha2_msg_schedule.sv
// Self-checking bench for sha2_msg_schedule: a 32-bit/64-round and a 64-bit/80-round instance
// checked against a textbook W[t] recurrence model, with directed and randomized blocks.
module tb_sha2_msg_schedule;

    logic CLK = 1'b0;
    logic RST_N;
    always #5 CLK = ~CLK;

    logic        start32, abort32, in_valid32, in_ready32, out_valid32, out_ready32, busy32, done32;
    logic [31:0] in_data32, out_data32;
    logic [5:0]  out_idx32;
    logic        start64, abort64, in_valid64, in_ready64, out_valid64, out_ready64, busy64, done64;
    logic [63:0] in_data64, out_data64;
    logic [6:0]  out_idx64;
`ifdef SHA2_WSCHED_CHKSUM_EN
    logic [31:0] chksum32;
    logic [63:0] chksum64;
`endif

    sha2_msg_schedule #(.WORD_W(32), .ROUNDS(64)) dut32 (
        .CLK(CLK), .RST_N(RST_N), .START(start32), .ABORT(abort32),
        .IN_VALID(in_valid32), .IN_READY(in_ready32), .IN_DATA(in_data32),
        .OUT_VALID(out_valid32), .OUT_READY(out_ready32), .OUT_DATA(out_data32),
        .OUT_IDX(out_idx32), .BUSY(busy32), .DONE(done32)
`ifdef SHA2_WSCHED_CHKSUM_EN
        , .CHKSUM(chksum32)
`endif
    );

    sha2_msg_schedule #(.WORD_W(64), .ROUNDS(80)) dut64 (
        .CLK(CLK), .RST_N(RST_N), .START(start64), .ABORT(abort64),
        .IN_VALID(in_valid64), .IN_READY(in_ready64), .IN_DATA(in_data64),
        .OUT_VALID(out_valid64), .OUT_READY(out_ready64), .OUT_DATA(out_data64),
        .OUT_IDX(out_idx64), .BUSY(busy64), .DONE(done64)
`ifdef SHA2_WSCHED_CHKSUM_EN
        , .CHKSUM(chksum64)
`endif
    );

    int n_pass  = 0;
    int n_total = 0;
    int n_fail  = 0;

    logic [31:0] blk32 [16];
    logic [31:0] w32m  [64];
    logic [31:0] got32 [64];
    logic [63:0] blk64 [16];
    logic [63:0] w64m  [80];
    logic [63:0] got64 [80];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] rotr32(input logic [31:0] x, input int n);
        logic [63:0] d;
        d = {x, x} >> n;
        return d[31:0];
    endfunction

    function automatic logic [63:0] rotr64(input logic [63:0] x, input int n);
        logic [127:0] d;
        d = {x, x} >> n;
        return d[63:0];
    endfunction

    // Textbook schedule: W[t] = s1(W[t-2]) + W[t-7] + s0(W[t-15]) + W[t-16]
    function automatic void model32();
        logic [31:0] s0, s1;
        for (int t = 0; t < 16; t++) w32m[t] = blk32[t];
        for (int t = 16; t < 64; t++) begin
            s0 = rotr32(w32m[t-15], 7) ^ rotr32(w32m[t-15], 18) ^ (w32m[t-15] >> 3);
            s1 = rotr32(w32m[t-2], 17) ^ rotr32(w32m[t-2], 19) ^ (w32m[t-2] >> 10);
            w32m[t] = s1 + w32m[t-7] + s0 + w32m[t-16];
        end
    endfunction

    function automatic void model64();
        logic [63:0] s0, s1;
        for (int t = 0; t < 16; t++) w64m[t] = blk64[t];
        for (int t = 16; t < 80; t++) begin
            s0 = rotr64(w64m[t-15], 1) ^ rotr64(w64m[t-15], 8) ^ (w64m[t-15] >> 7);
            s1 = rotr64(w64m[t-2], 19) ^ rotr64(w64m[t-2], 61) ^ (w64m[t-2] >> 6);
            w64m[t] = s1 + w64m[t-7] + s0 + w64m[t-16];
        end
    endfunction

    task automatic load32(input bit throttle, input int nwords);
        int k, g;
        bit v, rdy;
        k = 0;
        g = 0;
        start32 = 1'b1;
        @(posedge CLK); #1;
        start32 = 1'b0;
        chk("load32_busy", 64'(busy32), 64'd1);
        chk("load32_in_ready", 64'(in_ready32), 64'd1);
`ifdef SHA2_WSCHED_CHKSUM_EN
        chk("load32_chksum_cleared", 64'(chksum32), 64'd0);
`endif
        while (k < nwords && g < 400) begin
            v = throttle ? 1'($urandom_range(0, 1)) : 1'b1;
            in_valid32 = v;
            in_data32 = v ? blk32[k] : $urandom;
            rdy = in_ready32;
            @(posedge CLK); #1;
            if (v && rdy) k++;
            g++;
        end
        in_valid32 = 1'b0;
        chk("load32_words", 64'(k), 64'(nwords));
    endtask

    task automatic emit32(input bit throttle, input int abort_at);
        int t, g;
        bit rdy;
        t = 0;
        g = 0;
        while (t < 64 && g < 2000) begin
            chk("emit32_valid", 64'(out_valid32), 64'd1);
            chk("emit32_idx", 64'(out_idx32), 64'(t));
            chk("emit32_data", 64'(out_data32), 64'(w32m[t]));
            chk("emit32_busy", 64'(busy32), 64'd1);
            chk("emit32_no_done", 64'(done32), 64'd0);
            got32[t] = out_data32;
            if (t == abort_at) begin
                abort32 = 1'b1;
                out_ready32 = 1'b1;
                @(posedge CLK); #1;
                abort32 = 1'b0;
                out_ready32 = 1'b0;
                chk("abort_out_valid", 64'(out_valid32), 64'd0);
                chk("abort_busy", 64'(busy32), 64'd0);
                chk("abort_idx", 64'(out_idx32), 64'd0);
                chk("abort_data", 64'(out_data32), 64'd0);
                for (int c = 0; c < 4; c++) begin
                    chk("abort_no_done", 64'(done32), 64'd0);
                    @(posedge CLK); #1;
                end
                return;
            end
            rdy = throttle ? 1'($urandom_range(0, 1)) : 1'b1;
            out_ready32 = rdy;
            start32 = (t == 30);
            @(posedge CLK); #1;
            if (rdy) t++;
            g++;
        end
        start32 = 1'b0;
        out_ready32 = 1'b0;
        chk("emit32_words", 64'(t), 64'd64);
        chk("done32_pulse", 64'(done32), 64'd1);
        chk("done32_out_valid", 64'(out_valid32), 64'd0);
        chk("done32_busy", 64'(busy32), 64'd0);
        @(posedge CLK); #1;
        chk("done32_single", 64'(done32), 64'd0);
    endtask

    task automatic run64();
        int k, t, g;
        k = 0;
        t = 0;
        g = 0;
        start64 = 1'b1;
        @(posedge CLK); #1;
        start64 = 1'b0;
        chk("load64_busy", 64'(busy64), 64'd1);
        while (k < 16 && g < 100) begin
            in_valid64 = 1'b1;
            in_data64 = blk64[k];
            @(posedge CLK); #1;
            k++;
            g++;
        end
        in_valid64 = 1'b0;
        out_ready64 = 1'b1;
        while (t < 80 && g < 400) begin
            chk("emit64_valid", 64'(out_valid64), 64'd1);
            chk("emit64_idx", 64'(out_idx64), 64'(t));
            chk("emit64_data", out_data64, w64m[t]);
            got64[t] = out_data64;
            @(posedge CLK); #1;
            t++;
            g++;
        end
        out_ready64 = 1'b0;
        chk("emit64_words", 64'(t), 64'd80);
        chk("done64_pulse", 64'(done64), 64'd1);
        chk("done64_out_valid", 64'(out_valid64), 64'd0);
    endtask

    initial begin
        logic [31:0] x32;
        RST_N = 1'b0;
        {start32, abort32, in_valid32, out_ready32} = 4'b0000;
        {start64, abort64, in_valid64, out_ready64} = 4'b0000;
        in_data32 = 32'd0;
        in_data64 = 64'd0;
        repeat (2) @(posedge CLK);
        #1;
        chk("rst_in_ready", 64'(in_ready32), 64'd0);
        chk("rst_out_valid", 64'(out_valid32), 64'd0);
        chk("rst_busy", 64'(busy32), 64'd0);
        chk("rst_done", 64'(done32), 64'd0);
        chk("rst_idx", 64'(out_idx32), 64'd0);
        chk("rst_data", 64'(out_data32), 64'd0);
        chk("rst_out_valid64", 64'(out_valid64), 64'd0);
        RST_N = 1'b1;
        @(posedge CLK); #1;

        // T1: "abc" block, full throughput
        for (int i = 0; i < 16; i++) blk32[i] = 32'd0;
        blk32[0] = 32'h61626380;
        blk32[15] = 32'h00000018;
        model32();
        load32(1'b0, 16);
        emit32(1'b0, -1);
        chk("t1_w16", 64'(got32[16]), 64'h61626380);
        chk("t1_w17", 64'(got32[17]), 64'h000F0000);
`ifdef SHA2_WSCHED_CHKSUM_EN
        x32 = 32'd0;
        for (int i = 0; i < 64; i++) x32 = x32 ^ w32m[i];
        chk("t6_chksum_abc", 64'(chksum32), 64'(x32));
`else
        x32 = 32'd0;
`endif

        // T2: 64-bit "abc" block
        for (int i = 0; i < 16; i++) blk64[i] = 64'd0;
        blk64[0] = 64'h6162638000000000;
        blk64[15] = 64'h18;
        model64();
        run64();
        chk("t2_w16", got64[16], 64'h6162638000000000);
        chk("t2_w17", got64[17], 64'h00030000000000C0);

        // T3: throttled handshakes reproduce the T1 stream
        load32(1'b1, 16);
        emit32(1'b1, -1);

        // T4: abort at idx 20, then a clean rerun
        load32(1'b0, 16);
        emit32(1'b0, 20);
        load32(1'b0, 16);
        emit32(1'b0, -1);

        // Random blocks on both widths
        for (int i = 0; i < 16; i++) blk32[i] = $urandom;
        model32();
        load32(1'b1, 16);
        emit32(1'b1, -1);
        for (int i = 0; i < 16; i++) blk64[i] = {$urandom, $urandom};
        model64();
        run64();

        // T5: reset in the middle of LOAD, then an incomplete load
        load32(1'b0, 7);
        RST_N = 1'b0;
        #1;
        chk("t5_in_ready", 64'(in_ready32), 64'd0);
        chk("t5_busy", 64'(busy32), 64'd0);
        chk("t5_out_valid", 64'(out_valid32), 64'd0);
        chk("t5_data", 64'(out_data32), 64'd0);
        chk("t5_idx", 64'(out_idx32), 64'd0);
        chk("t5_done", 64'(done32), 64'd0);
        @(posedge CLK); #1;
        RST_N = 1'b1;
        load32(1'b0, 10);
        for (int c = 0; c < 20; c++) begin
            chk("t5_partial_no_valid", 64'(out_valid32), 64'd0);
            @(posedge CLK); #1;
        end
        abort32 = 1'b1;
        @(posedge CLK); #1;
        abort32 = 1'b0;
        chk("t5_abort_idle", 64'(busy32), 64'd0);

`ifdef SHA2_WSCHED_CHKSUM_EN
        // T6: all-zero block yields zero checksum after the START clear
        for (int i = 0; i < 16; i++) blk32[i] = 32'd0;
        model32();
        load32(1'b0, 16);
        emit32(1'b0, -1);
        chk("t6_chksum_zero", 64'(chksum32), 64'd0);
`endif

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
